rv32_single_cycle_core: RTL and testbench

//   Single-cycle RV32I-subset processor top: PC, instruction memory, decoder, 32x32 register

---
 rtl/rv32_pkg.sv | 64 ++++++
 rtl/rv32_alu.sv | 53 +++++
 rtl/rv32_dmem.sv | 34 +++
 rtl/rv32_imem.sv | 24 ++
 rtl/rv32_regfile.sv | 36 +++
 rtl/rv32_single_cycle_core.sv | 183 ++++++++++++++++++
 tb/tb_rv32_single_cycle_core.sv | 268 ++++++++++++++++++++++++++
 7 files changed

// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
//   Shared definitions for the RV32I-subset single-cycle core. It holds the
//   opcode, funct3 and funct7 constants, the ALU operation and immediate-format
//   enums, the writeback source enum, and the immediate generator.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package rv32_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT,
    ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;

  // Sign-extended immediate in the layout of the selected instruction format.
  function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_sel_t sel);
    logic [31:0] imm;
    case (sel)
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = {{20{ins[31]}}, ins[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/rv32_alu.sv
// ---------------------------------------------------------------------------
// rv32_alu
//   Combinational ALU. Shifts use b_i[4:0]. The flags are derived from the
//   operands so the branch unit can compare rs1 and rs2 (with op_i = ALU_SUB,
//   zero_o means the operands are equal).
//   Ports: op_i (alu_op_t), a_i/b_i operands, result_o, zero_o (result == 0),
//          lt_o (signed a < b), ltu_o (unsigned a < b).
// ---------------------------------------------------------------------------
module rv32_alu
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_t         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            lt_o,
  output logic            ltu_o
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic [4:0]             shamt;

  assign a_s   = a_i;
  assign b_s   = b_i;
  assign shamt = b_i[4:0];
  assign lt_o  = a_s < b_s;
  assign ltu_o = a_i < b_i;

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:    result_o = a_i + b_i;
      ALU_SUB:    result_o = a_i - b_i;
      ALU_AND:    result_o = a_i & b_i;
      ALU_OR:     result_o = a_i | b_i;
      ALU_XOR:    result_o = a_i ^ b_i;
      ALU_SLT:    result_o = {{(XLEN-1){1'b0}}, lt_o};
      ALU_SLTU:   result_o = {{(XLEN-1){1'b0}}, ltu_o};
      ALU_SLL:    result_o = a_i << shamt;
      ALU_SRL:    result_o = a_i >> shamt;
      ALU_SRA:    result_o = a_s >>> shamt;
      ALU_PASS_B: result_o = b_i;
      default:    result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/rv32_dmem.sv
// ---------------------------------------------------------------------------
// rv32_dmem
//   Word-addressed data memory with asynchronous read and synchronous write.
//   It has no reset, so its contents survive a core reset.
//   Ports: clk_i, we_i write enable, addr_i byte address (bits [1:0] ignored,
//          index wraps modulo WORDS), wdata_i, rdata_o.
// ---------------------------------------------------------------------------
module rv32_dmem #(
  parameter int XLEN  = 32,
  parameter int WORDS = 256
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o
);

  localparam int AW = $clog2(WORDS);

  logic [XLEN-1:0] data_memory [WORDS];
  logic [AW-1:0]   idx;
  logic            unused_addr;

  assign idx         = addr_i[AW+1:2];
  assign unused_addr = ^{addr_i[XLEN-1:AW+2], addr_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (we_i) data_memory[idx] <= wdata_i;
  end

  assign rdata_o = data_memory[idx];

endmodule

// File: rtl/rv32_imem.sv
// ---------------------------------------------------------------------------
// rv32_imem
//   Instruction memory with asynchronous read. It is preloaded externally by
//   writing instruction_memory directly, and it is never cleared.
//   Ports: addr_i byte address (bits [1:0] ignored, index wraps modulo WORDS),
//          rdata_o instruction word.
// ---------------------------------------------------------------------------
module rv32_imem #(
  parameter int XLEN  = 32,
  parameter int WORDS = 256
) (
  input  logic [XLEN-1:0] addr_i,
  output logic [31:0]     rdata_o
);

  localparam int AW = $clog2(WORDS);

  logic [31:0] instruction_memory [WORDS];
  logic        unused_addr;

  assign unused_addr = ^{addr_i[XLEN-1:AW+2], addr_i[1:0]};
  assign rdata_o     = instruction_memory[addr_i[AW+1:2]];

endmodule

// File: rtl/rv32_regfile.sv
// ---------------------------------------------------------------------------
// rv32_regfile
//   32 x XLEN register file with 2 read ports and 1 write port. Reads are
//   asynchronous and writes are synchronous. Reset clears every entry.
//   x0 always reads 0, and writes to x0 are dropped.
//   Ports: clk_i, rst_i (sync, active-high), we_i/waddr_i/wdata_i write port,
//          raddr1_i/raddr2_i read addresses, rdata1_o/rdata2_o read data.
// ---------------------------------------------------------------------------
module rv32_regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] RF [32];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) RF[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      RF[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? '0 : RF[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0 : RF[raddr2_i];

endmodule

// File: rtl/rv32_single_cycle_core.sv
// ---------------------------------------------------------------------------
// rv32_single_cycle_core
//   Single-cycle RV32I-subset core. Fetch, decode, ALU and data-memory read
//   are combinational. The register write, memory write and PC update all
//   commit on the same rising edge. Unsupported encodings behave as a NOP.
//   Ports: clk   clock
//          n_rst synchronous reset, active-high despite the name
// ---------------------------------------------------------------------------
module rv32_single_cycle_core
  import rv32_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input logic clk,
  input logic n_rst
);

  logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
  logic [31:0]     instr;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  alu_op_t         alu_op;
  imm_sel_t        imm_sel;
  wb_sel_t         wb_sel;
  logic            use_imm, rf_we, dm_we, is_branch, is_jal, is_jalr;
  logic            br_cond, br_taken;
  logic [XLEN-1:0] imm, rs1_val, rs2_val, alu_b, alu_res, dm_rdata, wb_data;
  logic            alu_zero, alu_lt, alu_ltu;

  rv32_imem #(.XLEN(XLEN), .WORDS(IMEM_WORDS)) DUT_instr (
    .addr_i(pc_q), .rdata_o(instr)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // Decoder: every control signal starts at its NOP value, so any encoding
  // that does not match falls through without writing state.
  always_comb begin
    alu_op    = ALU_ADD;
    imm_sel   = IMM_I;
    wb_sel    = WB_ALU;
    use_imm   = 1'b0;
    rf_we     = 1'b0;
    dm_we     = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OP: begin
        rf_we = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, F3_ADD}:  alu_op = ALU_ADD;
          {F7_ALT,  F3_ADD}:  alu_op = ALU_SUB;
          {F7_BASE, F3_SLL}:  alu_op = ALU_SLL;
          {F7_BASE, F3_SLT}:  alu_op = ALU_SLT;
          {F7_BASE, F3_SLTU}: alu_op = ALU_SLTU;
          {F7_BASE, F3_XOR}:  alu_op = ALU_XOR;
          {F7_BASE, F3_SR}:   alu_op = ALU_SRL;
          {F7_ALT,  F3_SR}:   alu_op = ALU_SRA;
          {F7_BASE, F3_OR}:   alu_op = ALU_OR;
          {F7_BASE, F3_AND}:  alu_op = ALU_AND;
          default:            rf_we  = 1'b0;
        endcase
      end
      OP_IMM: begin
        rf_we   = 1'b1;
        use_imm = 1'b1;
        case (funct3)
          F3_ADD:  alu_op = ALU_ADD;
          F3_SLT:  alu_op = ALU_SLT;
          F3_SLTU: alu_op = ALU_SLTU;
          F3_XOR:  alu_op = ALU_XOR;
          F3_OR:   alu_op = ALU_OR;
          F3_AND:  alu_op = ALU_AND;
          F3_SLL:  if (funct7 == F7_BASE) alu_op = ALU_SLL; else rf_we = 1'b0;
          default: begin
            // Shift-right immediates: funct7 selects logical or arithmetic.
            if (funct7 == F7_BASE)     alu_op = ALU_SRL;
            else if (funct7 == F7_ALT) alu_op = ALU_SRA;
            else                       rf_we  = 1'b0;
          end
        endcase
      end
      LOAD: if (funct3 == F3_LW) begin
        rf_we   = 1'b1;
        use_imm = 1'b1;
        wb_sel  = WB_MEM;
      end
      STORE: if (funct3 == F3_SW) begin
        dm_we   = 1'b1;
        use_imm = 1'b1;
        imm_sel = IMM_S;
      end
      BRANCH: if (funct3 != 3'b010 && funct3 != 3'b011) begin
        is_branch = 1'b1;
        alu_op    = ALU_SUB;
        imm_sel   = IMM_B;
      end
      LUI: begin
        rf_we   = 1'b1;
        use_imm = 1'b1;
        imm_sel = IMM_U;
        alu_op  = ALU_PASS_B;
      end
      JAL: begin
        rf_we   = 1'b1;
        wb_sel  = WB_PC4;
        is_jal  = 1'b1;
        imm_sel = IMM_J;
      end
      JALR: if (funct3 == F3_JALR) begin
        rf_we   = 1'b1;
        wb_sel  = WB_PC4;
        is_jalr = 1'b1;
        use_imm = 1'b1;
      end
      default: ;
    endcase
  end

  assign imm   = imm_gen(instr, imm_sel);
  assign alu_b = use_imm ? imm : rs2_val;

  rv32_regfile #(.XLEN(XLEN)) DUT_RF (
    .clk_i(clk), .rst_i(n_rst), .we_i(rf_we), .waddr_i(rd), .wdata_i(wb_data),
    .raddr1_i(rs1), .raddr2_i(rs2), .rdata1_o(rs1_val), .rdata2_o(rs2_val)
  );

  rv32_alu #(.XLEN(XLEN)) u_alu (
    .op_i(alu_op), .a_i(rs1_val), .b_i(alu_b), .result_o(alu_res),
    .zero_o(alu_zero), .lt_o(alu_lt), .ltu_o(alu_ltu)
  );

  // Loads and stores both address memory with rs1 + imm from the ALU.
  rv32_dmem #(.XLEN(XLEN), .WORDS(DMEM_WORDS)) DUT_Data (
    .clk_i(clk), .we_i(dm_we), .addr_i(alu_res), .wdata_i(rs2_val), .rdata_o(dm_rdata)
  );

  always_comb begin
    case (funct3)
      F3_BEQ:  br_cond = alu_zero;
      F3_BNE:  br_cond = ~alu_zero;
      F3_BLT:  br_cond = alu_lt;
      F3_BGE:  br_cond = ~alu_lt;
      F3_BLTU: br_cond = alu_ltu;
      F3_BGEU: br_cond = ~alu_ltu;
      default: br_cond = 1'b0;
    endcase
  end

  assign br_taken = is_branch & br_cond;
  assign pc_plus4 = pc_q + XLEN'(4);

  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_data = dm_rdata;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_res;
    endcase
  end

  // The branch or jal target is PC-relative. The jalr target comes from the
  // ALU sum with bit 0 cleared.
  always_comb begin
    if (br_taken || is_jal) pc_d = pc_q + imm;
    else if (is_jalr)       pc_d = {alu_res[XLEN-1:1], 1'b0};
    else                    pc_d = pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (n_rst) pc_q <= '0;
    else       pc_q <= pc_d;
  end

endmodule

// File: tb/tb_rv32_single_cycle_core.sv
// ---------------------------------------------------------------------------
// tb_rv32_single_cycle_core
//   Directed programs with hand-computed register, memory and PC results.
// ---------------------------------------------------------------------------
module tb_rv32_single_cycle_core;

  logic clk   = 1'b0;
  logic n_rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] OPI = 32'h13;

  logic [31:0] prog [256];
  int          np;

  rv32_single_cycle_core #(.XLEN(32), .IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
    .clk(clk), .n_rst(n_rst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [31:0] f7, rs2, rs1, f3, rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [31:0] imm, rs1, f3, rd, opc);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], opc[6:0]};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, rs2, rs1, f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, rs2, rs1, f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [31:0] imm20, rd);
    return {imm20[19:0], rd[4:0], 7'b0110111};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction
  function automatic logic [31:0] addi(input logic [31:0] rd, rs1, imm);
    return enc_i(imm, rs1, 0, rd, OPI);
  endfunction

  function automatic logic [31:0] rf(input int i);
    return dut.DUT_RF.RF[i];
  endfunction
  function automatic logic [31:0] dm(input int i);
    return dut.DUT_Data.data_memory[i];
  endfunction
  function automatic logic [31:0] pc();
    return dut.pc_q;
  endfunction
  function automatic int rf_nonzero();
    int c = 0;
    for (int i = 0; i < 32; i++) if (rf(i) !== 32'd0) c++;
    return c;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic emit(input logic [31:0] w);
    prog[np] = w;
    np++;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++)
      dut.DUT_instr.instruction_memory[i] = (i < np) ? prog[i] : NOP;
    np = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    n_rst = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic arith_prog();
    emit(addi(1, 0, 10));
    emit(addi(2, 0, 5));
    emit(enc_r(0, 2, 1, 0, 3));
    emit(enc_r(32, 2, 1, 0, 4));
    load_prog();
  endtask

  task automatic check_arith(input string tag);
    check_eq({tag, "_x1"}, rf(1), 32'd10);
    check_eq({tag, "_x2"}, rf(2), 32'd5);
    check_eq({tag, "_x3"}, rf(3), 32'd15);
    check_eq({tag, "_x4"}, rf(4), 32'd5);
    check_eq({tag, "_pc"}, pc(), 32'd28);
  endtask

  initial begin
    np = 0;

    // Arithmetic, including the reset state
    arith_prog();
    do_reset();
    check_eq("rst_pc", pc(), 32'd0);
    check_eq("rst_rf_clear", rf_nonzero(), 32'd0);
    step(7);
    check_arith("arith");

    // Reset in the middle of the same program
    do_reset();
    step(3);
    check_eq("mid_partial_x3", rf(3), 32'd15);
    do_reset();
    check_eq("mid_rst_pc", pc(), 32'd0);
    check_eq("mid_rst_rf_clear", rf_nonzero(), 32'd0);
    step(7);
    check_arith("rerun");

    // Memory: store/load, index wrap, ignored low address bits
    emit(addi(1, 0, 100));
    emit(enc_s(0, 1, 0, 2));
    emit(enc_i(0, 0, 2, 2, 3));
    emit(addi(3, 2, 1));
    emit(enc_s(1028, 3, 0, 2));
    emit(enc_i(7, 0, 2, 4, 3));
    load_prog();
    do_reset();
    step(7);
    check_eq("mem_x1", rf(1), 32'd100);
    check_eq("mem_dm0", dm(0), 32'd100);
    check_eq("mem_x2", rf(2), 32'd100);
    check_eq("mem_x3", rf(3), 32'd101);
    check_eq("mem_wrap_dm1", dm(1), 32'd101);
    check_eq("mem_lowbits_x4", rf(4), 32'd101);
    do_reset();
    check_eq("mem_kept_dm0", dm(0), 32'd100);
    check_eq("mem_rst_x1", rf(1), 32'd0);

    // Branch loop
    emit(addi(2, 0, 5));
    emit(addi(1, 1, 1));
    emit(enc_b(-4, 2, 1, 1));
    load_prog();
    do_reset();
    step(20);
    check_eq("loop_x1", rf(1), 32'd5);
    check_eq("loop_x2", rf(2), 32'd5);
    check_eq("loop_pc", pc(), 32'd48);

    // Logic ops, immediates, compares and the remaining branch types
    emit(addi(1, 0, 240));
    emit(addi(2, 0, 255));
    emit(addi(7, 0, 4));
    emit(enc_r(0, 2, 1, 7, 3));
    emit(enc_r(0, 2, 1, 6, 4));
    emit(enc_r(0, 2, 1, 4, 5));
    emit(enc_r(0, 7, 1, 1, 6));
    emit(enc_i(-16, 2, 7, 8, OPI));
    emit(enc_i(7, 1, 6, 9, OPI));
    emit(enc_i(-1, 1, 4, 10, OPI));
    emit(enc_i(-1, 1, 2, 11, OPI));
    emit(enc_i(-1, 1, 3, 12, OPI));
    emit(enc_b(8, 8, 3, 0));
    emit(addi(13, 0, 1));
    emit(enc_b(8, 1, 2, 5));
    emit(addi(14, 0, 1));
    emit(enc_b(8, 2, 1, 7));
    emit(addi(15, 0, 1));
    emit(enc_i(28, 10, 5, 16, OPI));
    emit(enc_r(0, 10, 10, 0, 17));
    load_prog();
    do_reset();
    step(18);
    check_eq("and", rf(3), 32'h0000_00F0);
    check_eq("or", rf(4), 32'h0000_00FF);
    check_eq("xor", rf(5), 32'h0000_000F);
    check_eq("sll", rf(6), 32'h0000_0F00);
    check_eq("andi_neg", rf(8), 32'h0000_00F0);
    check_eq("ori", rf(9), 32'h0000_00F7);
    check_eq("xori_neg", rf(10), 32'hFFFF_FF0F);
    check_eq("slti", rf(11), 32'd0);
    check_eq("sltiu", rf(12), 32'd1);
    check_eq("beq_taken", rf(13), 32'd0);
    check_eq("bge_taken", rf(14), 32'd0);
    check_eq("bgeu_not_taken", rf(15), 32'd1);
    check_eq("srli", rf(16), 32'h0000_000F);
    check_eq("add_wrap", rf(17), 32'hFFFF_FE1E);
    check_eq("logic_pc", pc(), 32'd80);

    // Jumps, signed/unsigned compares, lui and arithmetic shifts
    emit(enc_j(8, 5));
    emit(addi(9, 0, 1));
    emit(addi(1, 0, -1));
    emit(addi(2, 0, 1));
    emit(enc_r(0, 2, 1, 2, 3));
    emit(enc_r(0, 2, 1, 3, 4));
    emit(enc_b(8, 2, 1, 4));
    emit(addi(9, 0, 2));
    emit(enc_b(8, 2, 1, 6));
    emit(addi(10, 0, 3));
    emit(enc_u(32'h80000, 6));
    emit(enc_i(32'h404, 6, 5, 7, OPI));
    emit(enc_r(0, 2, 6, 5, 8));
    emit(enc_i(61, 0, 0, 12, 32'h67));
    emit(addi(9, 0, 4));
    emit(addi(13, 0, -2048));
    load_prog();
    do_reset();
    step(1);
    check_eq("jal_link", rf(5), 32'd4);
    check_eq("jal_pc", pc(), 32'd8);
    step(12);
    check_eq("slt_neg", rf(3), 32'd1);
    check_eq("sltu_neg", rf(4), 32'd0);
    check_eq("skipped_never_ran", rf(9), 32'd0);
    check_eq("bltu_not_taken", rf(10), 32'd3);
    check_eq("lui", rf(6), 32'h8000_0000);
    check_eq("srai", rf(7), 32'hF800_0000);
    check_eq("srl", rf(8), 32'h4000_0000);
    check_eq("jalr_link", rf(12), 32'd56);
    check_eq("imm_min", rf(13), 32'hFFFF_F800);
    check_eq("jump_pc", pc(), 32'd64);

    // x0 writes and unsupported encodings
    emit(addi(1, 0, 42));
    emit(addi(0, 0, 7));
    emit(32'hFFFF_FFFF);
    emit(enc_s(8, 1, 0, 1));
    emit(enc_r(1, 1, 1, 0, 5));
    load_prog();
    dut.DUT_Data.data_memory[2] = 32'hDEAD_BEEF;
    do_reset();
    step(1);
    check_eq("nop_setup_x1", rf(1), 32'd42);
    step(1);
    check_eq("x0_write_dropped", rf(0), 32'd0);
    check_eq("x0_pc", pc(), 32'd8);
    step(1);
    check_eq("invalid_pc", pc(), 32'd12);
    begin
      int diff = 0;
      for (int i = 0; i < 32; i++)
        if (rf(i) !== ((i == 1) ? 32'd42 : 32'd0)) diff++;
      check_eq("invalid_rf_unchanged", diff, 32'd0);
    end
    step(1);
    check_eq("sh_no_store", dm(2), 32'hDEAD_BEEF);
    check_eq("sh_pc", pc(), 32'd16);
    step(1);
    check_eq("bad_funct7_no_write", rf(5), 32'd0);
    check_eq("bad_funct7_pc", pc(), 32'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
